// File: rtl/result_drain_fsm.sv
// Result drain for mac_array: captures each lane's accumulator on its first valid_out, streams
// the words out over valid/ready, then pulses clear. Optional build macro: DRAIN_RELU_EN.
module result_drain_fsm #(
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_MACS-1:0]       valid_in,
  input  logic signed [ACC_W-1:0] acc_in_0,
  input  logic signed [ACC_W-1:0] acc_in_1,
  input  logic signed [ACC_W-1:0] acc_in_2,
  input  logic signed [ACC_W-1:0] acc_in_3,
  output logic signed [ACC_W-1:0] out_data,
  output logic [1:0]              out_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [N_MACS-1:0]       clear,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {StIdle, StWait, StSend, StClr} state_e;

  state_e                  state_q, state_d;
  logic [N_MACS-1:0]       cap_mask_q, cap_mask_d;
  logic [1:0]              idx_q, idx_d;
  logic signed [ACC_W-1:0] cap_reg_q [N_MACS];
  logic signed [ACC_W-1:0] cap_reg_d [N_MACS];
  logic signed [ACC_W-1:0] acc_in [N_MACS];
  logic signed [ACC_W-1:0] sel_word;
  logic signed [ACC_W-1:0] drain_word;
  logic                    last_lane;

  assign acc_in[0] = acc_in_0;
  assign acc_in[1] = acc_in_1;
  assign acc_in[2] = acc_in_2;
  assign acc_in[3] = acc_in_3;

  assign sel_word  = cap_reg_q[idx_q];
  assign last_lane = (idx_q == 2'(N_MACS - 1));

`ifdef DRAIN_RELU_EN
  assign drain_word = (sel_word < 0) ? '0 : sel_word;
`else
  assign drain_word = sel_word;
`endif

  always_comb begin
    state_d    = state_q;
    cap_mask_d = cap_mask_q;
    idx_d      = idx_q;
    cap_reg_d  = cap_reg_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StWait;
          cap_mask_d = '0;
          idx_d      = '0;
        end
      end
      StWait: begin
        // First capture per lane wins; later valids on a captured lane are dropped.
        for (int i = 0; i < N_MACS; i++) begin
          if (valid_in[i] && !cap_mask_q[i]) begin
            cap_reg_d[i]  = acc_in[i];
            cap_mask_d[i] = 1'b1;
          end
        end
        if (&(cap_mask_q | valid_in)) begin
          state_d = StSend;
          idx_d   = '0;
        end
      end
      StSend: begin
        if (out_ready) begin
          if (last_lane) state_d = StClr;
          else           idx_d   = idx_q + 2'd1;
        end
      end
      StClr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cap_mask_q <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      cap_mask_q <= cap_mask_d;
      idx_q      <= idx_d;
    end
  end

  // Capture registers are only read after being written in the same round.
  always_ff @(posedge clk) begin
    cap_reg_q <= cap_reg_d;
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    clear     = '0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      StIdle: busy = 1'b0;
      StWait: ;
      StSend: begin
        out_valid = 1'b1;
        out_idx   = idx_q;
        out_last  = last_lane;
        out_data  = drain_word;
      end
      StClr: begin
        clear = '1;
        done  = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_result_drain_fsm.sv
// Table-driven bench for result_drain_fsm, plus a hand-written mid-round async reset sequence.
module tb_result_drain_fsm;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [3:0]         valid_in;
  logic signed [15:0] acc_in_0, acc_in_1, acc_in_2, acc_in_3;
  logic signed [15:0] out_data;
  logic [1:0]         out_idx;
  logic               out_valid, out_ready, out_last, busy, done;
  logic [3:0]         clear;

  int total = 0;
  int bad   = 0;

  result_drain_fsm #(.ACC_W(16), .N_MACS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .valid_in  (valid_in),
    .acc_in_0  (acc_in_0),
    .acc_in_1  (acc_in_1),
    .acc_in_2  (acc_in_2),
    .acc_in_3  (acc_in_3),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .clear     (clear),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               st;
    logic [3:0]         vi;
    logic signed [15:0] a0, a1, a2, a3;
    logic               rd;
    logic               ev;
    logic signed [15:0] ed;
    logic [1:0]         ei;
    logic               el;
    logic [3:0]         ec;
    logic               eb;
    logic               edn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit st, bit [3:0] vi, int a0, int a1, int a2, int a3, bit rd,
                              bit ev, int ed, int ei, bit el, bit [3:0] ec, bit eb, bit edn);
    vec_t v;
    v.st = st; v.vi = vi; v.rd = rd;
    v.a0 = 16'(a0); v.a1 = 16'(a1); v.a2 = 16'(a2); v.a3 = 16'(a3);
    v.ev = ev; v.ed = 16'(ed); v.ei = 2'(ei); v.el = el; v.ec = ec; v.eb = eb; v.edn = edn;
    return v;
  endfunction

  // Idle outputs expected.
  function automatic vec_t idl(bit st, bit rd);
    return mk(st, 4'h0, 0, 0, 0, 0, rd, 0, 0, 0, 0, 4'h0, 0, 0);
  endfunction
  // WAIT outputs expected (busy only).
  function automatic vec_t wt(bit st, bit [3:0] vi, int a0, int a1, int a2, int a3, bit rd);
    return mk(st, vi, a0, a1, a2, a3, rd, 0, 0, 0, 0, 4'h0, 1, 0);
  endfunction
  // SEND outputs expected.
  function automatic vec_t snd(bit st, bit rd, int ed, int ei);
    return mk(st, 4'h0, 0, 0, 0, 0, rd, 1, ed, ei, ei == 3, 4'h0, 1, 0);
  endfunction
  // CLR outputs expected.
  function automatic vec_t clr(bit st, bit rd);
    return mk(st, 4'h0, 0, 0, 0, 0, rd, 0, 0, 0, 0, 4'hF, 1, 1);
  endfunction

  task automatic check(string name, logic ev, logic signed [15:0] ed, logic [1:0] ei, logic el,
                       logic [3:0] ec, logic eb, logic edn);
    total++;
    if ({out_valid, out_data, out_idx, out_last, clear, busy, done} !==
        {ev, ed, ei, el, ec, eb, edn}) begin
      bad++;
      $display("FAIL %s: got v=%b d=%0d i=%0d l=%b c=%b b=%b dn=%b want v=%b d=%0d i=%0d l=%b c=%b b=%b dn=%b",
               name, out_valid, out_data, out_idx, out_last, clear, busy, done,
               ev, ed, ei, el, ec, eb, edn);
    end
  endtask

  // Drive one vector, check outputs away from the edge, then let the edge sample the inputs.
  task automatic apply(vec_t v, string name);
    start = v.st; valid_in = v.vi; out_ready = v.rd;
    acc_in_0 = v.a0; acc_in_1 = v.a1; acc_in_2 = v.a2; acc_in_3 = v.a3;
    @(negedge clk);
    check(name, v.ev, v.ed, v.ei, v.el, v.ec, v.eb, v.edn);
    @(posedge clk);
    #1;
  endtask

  int r0, r2;

  initial begin
    rst = 1'b1; start = 1'b0; valid_in = '0; out_ready = 1'b0;
    acc_in_0 = '0; acc_in_1 = '0; acc_in_2 = '0; acc_in_3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, 0, 0, 0, 4'h0, 0, 0);
    rst = 1'b0;

`ifdef DRAIN_RELU_EN
    r0 = 0; r2 = 0;
`else
    r0 = -7; r2 = -32768;
`endif

    // Basic round, out_ready held high throughout.
    vecs.push_back(idl(1, 1));
    vecs.push_back(wt(0, 4'b1111, 20, 30, 40, 50, 1));
    vecs.push_back(snd(0, 1, 20, 0));
    vecs.push_back(snd(0, 1, 30, 1));
    vecs.push_back(snd(0, 1, 40, 2));
    vecs.push_back(snd(0, 1, 50, 3));
    vecs.push_back(clr(0, 1));
    vecs.push_back(idl(0, 1));
    // Staggered valids; each lane value changes after its valid.
    vecs.push_back(idl(1, 1));
    vecs.push_back(wt(0, 4'b0001, 11, 0, 0, 0, 1));
    vecs.push_back(wt(0, 4'b0010, 99, 12, 0, 0, 1));
    vecs.push_back(wt(0, 4'b0100, 99, 98, 13, 0, 1));
    vecs.push_back(wt(0, 4'b1000, 99, 98, 97, 14, 1));
    vecs.push_back(snd(0, 1, 11, 0));
    vecs.push_back(snd(0, 1, 12, 1));
    vecs.push_back(snd(0, 1, 13, 2));
    vecs.push_back(snd(0, 1, 14, 3));
    vecs.push_back(clr(0, 1));
    vecs.push_back(idl(0, 0));
    // Duplicate valid on lane 0, backpressure 1,0,0,1,0,1,1, start while busy.
    vecs.push_back(idl(1, 0));
    vecs.push_back(wt(0, 4'b0001, 20, 0, 0, 0, 0));
    vecs.push_back(wt(0, 4'b0001, 99, 0, 0, 0, 0));
    vecs.push_back(wt(0, 4'b1111, 99, 5, 6, 7, 0));
    vecs.push_back(snd(0, 1, 20, 0));
    vecs.push_back(snd(0, 0, 5, 1));
    vecs.push_back(snd(1, 0, 5, 1));
    vecs.push_back(snd(0, 1, 5, 1));
    vecs.push_back(snd(0, 0, 6, 2));
    vecs.push_back(snd(1, 1, 6, 2));
    vecs.push_back(snd(0, 1, 7, 3));
    vecs.push_back(clr(1, 0));
    vecs.push_back(idl(0, 0));
    vecs.push_back(idl(0, 0));
    // Negative / extreme values through the optional rectifier.
    vecs.push_back(idl(1, 1));
    vecs.push_back(wt(0, 4'b1111, -7, 30, -32768, 0, 1));
    vecs.push_back(snd(0, 1, r0, 0));
    vecs.push_back(snd(0, 1, 30, 1));
    vecs.push_back(snd(0, 1, r2, 2));
    vecs.push_back(snd(0, 1, 0, 3));
    vecs.push_back(clr(0, 1));
    vecs.push_back(idl(0, 1));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of SEND, then a clean round.
    apply(idl(1, 0), "rst_pre0");
    apply(wt(0, 4'b1111, 1, 2, 3, 4, 0), "rst_pre1");
    start = 1'b0; valid_in = '0; out_ready = 1'b0;
    @(negedge clk);
    check("rst_send", 1, 1, 0, 0, 4'h0, 1, 0);
    #2 rst = 1'b1;
    #1 check("rst_async", 0, 0, 0, 0, 4'h0, 0, 0);
    @(posedge clk);
    #1 check("rst_held", 0, 0, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    apply(idl(0, 1), "rst_post_idle");
    apply(idl(1, 1), "rst_post0");
    apply(wt(0, 4'b1111, 7, 8, 9, 10, 1), "rst_post1");
    apply(snd(0, 1, 7, 0), "rst_post2");
    apply(snd(0, 1, 8, 1), "rst_post3");
    apply(snd(0, 1, 9, 2), "rst_post4");
    apply(snd(0, 1, 10, 3), "rst_post5");
    apply(clr(0, 1), "rst_post6");
    apply(idl(0, 1), "rst_post7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_drain_fsm.md
# result_drain_fsm

Read side of the MAC array loading protocol: once the loading FSM has driven operands into `mac_array`, this block watches the array's per-lane `valid_out`, latches each lane's accumulator, and streams the results out one lane at a time over a valid/ready handshake. After the last word is accepted it pulses the array's `clear` so the next loading phase starts from zero. It sits between `mac_array` outputs and the downstream result sink or writeback buffer.

## Interface
Parameters:
- `ACC_W`, 16, accumulator and output word width
- `N_MACS`, 4, lane count; the accumulator input ports are fixed at four (`acc_in_0..3`), so only 4 is supported

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  arm pulse; starts one capture/drain round
- `valid_in`  in  N_MACS  per-lane result valid, from `mac_array.valid_out`
- `acc_in_0`..`acc_in_3`  in  ACC_W each  signed lane accumulators, from `mac_array.acc_out_*`
- `out_data`  out  ACC_W  signed result word
- `out_idx`  out  2  lane index of `out_data`
- `out_valid`  out  1  `out_data`/`out_idx`/`out_last` are valid
- `out_ready`  in  1  sink accepts the word when `out_valid` and `out_ready` are both high
- `out_last`  out  1  high with lane N_MACS-1
- `clear`  out  N_MACS  one-cycle all-ones pulse to `mac_array.clear`
- `busy`  out  1  high in WAIT, SEND, CLR
- `done`  out  1  one-cycle pulse when a round completes

## Operation
- States: IDLE, WAIT, SEND, CLR.
- IDLE: `start`=1 moves to WAIT and zeroes `cap_mask`. `valid_in` is ignored.
- WAIT: for each lane i where `valid_in[i]`=1 and `cap_mask[i]`=0, latch `acc_in_i` into `cap_reg[i]` and set `cap_mask[i]`.
  - First capture wins. A repeated `valid_in[i]` on a lane that is already captured is ignored.
  - When `(cap_mask | valid_in)` is all ones, go to SEND with `idx`=0.
- SEND: drive `out_valid`=1, `out_idx`=`idx`, and `out_data`=f(`cap_reg[idx]`).
  - On a handshake with `idx`<N_MACS-1, increment `idx`.
  - On a handshake with `idx`=N_MACS-1, go to CLR.
- CLR: `clear`=all ones and `done`=1 for exactly one cycle, then go to IDLE.
- `start` is ignored while `busy`=1; it is neither queued nor allowed to restart the round.
- f is the identity unless `DRAIN_RELU_EN` is defined (see Configuration).
- No arithmetic is done on data; output width equals ACC_W with no truncation.

## Timing
- Reset values: `out_data`=0, `out_idx`=0, `out_valid`=0, `out_last`=0, `clear`=0, `busy`=0, `done`=0, state=IDLE, `cap_mask`=0.
- `start` sampled high at edge k gives `busy`=1 from k onward.
- Capture timing:
  - The earliest capture is of `valid_in` sampled at edge k+1.
  - If all lanes are valid in that same cycle, `out_valid` rises after edge k+1.
- Latency:
  - From the edge where the mask completes, the first `out_valid` follows one cycle later.
  - With `out_ready` held high, one word is accepted per cycle and lane 3 is accepted N_MACS cycles after SEND entry.
- `clear`/`done` are asserted in the cycle after the last handshake. `busy` drops after that cycle.
- Hold rule: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_idx`, and `out_last` stay stable.
- `out_valid` never deasserts without a handshake, except on reset.
- `out_ready` may be high before `out_valid`; it has no effect outside SEND.
- Reset mid-round (any state): everything returns immediately to the reset values and no `clear` pulse is issued.
- `cap_reg` contents need not be reset; they are never output before being captured.

## Configuration
- `DRAIN_RELU_EN`: when defined, `out_data` = (`cap_reg[idx]` < 0) ? 0 : `cap_reg[idx]`. The signed compare is on the full ACC_W.
- When undefined, `out_data` = `cap_reg[idx]` unchanged.
- Capture and handshake timing are identical in both builds.

## Test plan
- Basic round: lanes hold 20, 30, 40, 50; `start`, then `valid_in`=4'b1111 for one cycle, `out_ready`=1 -> words 20, 30, 40, 50 with idx 0..3 on consecutive cycles; `out_last` on 50; `clear`=4'b1111 and `done` for one cycle; `busy` low afterwards.
- Staggered valids: `valid_in` = 0001, 0010, 0100, 1000 on successive cycles, with the lane value changed after each valid -> the outputs are the values present at each lane's valid; SEND begins only after the 1000 cycle.
- Backpressure: `out_ready` toggled 1,0,0,1,0,1,1 -> exactly 4 handshakes, data held stable during stalls, no word skipped or duplicated.
- Duplicate valid: lane 0 gets valid with 20, then valid again with 99 before the mask completes -> 20 is output for idx 0.
- Start while busy and reset: `start` pulsed during SEND -> no restart. `rst` asserted mid-SEND -> all outputs go to 0 asynchronously, with no `clear` pulse. A new round afterwards completes normally.
- `DRAIN_RELU_EN` build: lanes -7, 30, -32768, 0 -> outputs 0, 30, 0, 0. Without the macro -> -7, 30, -32768, 0.
